instr_mem_loadable: RTL and testbench

- Parametrised, clocked instruction memory for the single-cycle MIPS core.
- Replaces hard-coded program contents with a run-time loader port. A word-wise valid/ready handshake fills the array after reset.
- Serves byte-addressed, word-aligned fetches with one-cycle registered latency.
- Flags misaligned and out-of-range PCs instead of reading garbage.

---
 rtl/mips_imem_pkg.sv | 22 ++
 rtl/imem_word_ram.sv | 27 ++
 rtl/instr_mem_loadable.sv | 131 +++++++++++++
 tb/tb_instr_mem_loadable.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_imem_pkg.sv
// rtl/mips_imem_pkg.sv - shared types, constants and address helpers for the loadable instruction memory
package mips_imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_NOP_WORD   = 32'h0000_0000;
   localparam int          IMEM_ADDR_MAX_W = 64;
   localparam int          IMEM_IDX_W      = IMEM_ADDR_MAX_W - 2;

   function automatic logic [IMEM_IDX_W-1:0] word_index(input logic [IMEM_ADDR_MAX_W-1:0] addr);
      return IMEM_IDX_W'(addr >> 2);
   endfunction

   function automatic logic is_aligned(input logic [IMEM_ADDR_MAX_W-1:0] addr);
      return (addr & 64'h3) == 64'h0;
   endfunction

endpackage

// File: rtl/imem_word_ram.sv
// rtl/imem_word_ram.sv - synchronous-write, synchronous-read word array, contents not reset
module imem_word_ram #(
   parameter int DEPTH_WORDS = 20,
   parameter int AW          = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // rdata only moves on a read, so the last fetched word is held between requests
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - run-time loadable instruction memory with registered, fault-checked fetch
module instr_mem_loadable
   import mips_imem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 20,
   parameter int          ADDR_W      = 32,
   parameter int          CNT_W       = $clog2(DEPTH_WORDS) + 1,
   parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [CNT_W-1:0]  load_len,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   output logic              load_ready,
   output logic              load_done,
   output logic              running,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [31:0]       instruction,
   output logic              instr_valid,
   output logic              addr_fault
);

   localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   imem_state_e            state_q, state_d;
   logic [CNT_W-1:0]       len_q;
   logic [CNT_W-1:0]       ptr_q;
   logic [DEPTH_WORDS-1:0] written_q;
   logic                   load_done_q, done_d;
   logic                   instr_valid_q;
   logic                   addr_fault_q;
   logic                   resp_ram_q;

   logic [IMEM_ADDR_MAX_W-1:0] addr_ext;
   logic [IMEM_IDX_W-1:0]      idx;
   logic [RAM_AW-1:0]          raddr;
   logic                       fault;
   logic                       accept;
   logic                       last_word;
   logic                       fetch_go;
   logic [CNT_W-1:0]           len_clamped;
   logic [31:0]                ram_rdata;

   assign addr_ext = IMEM_ADDR_MAX_W'(fetch_addr);
   assign idx      = word_index(addr_ext);
   assign raddr    = idx[RAM_AW-1:0];
   assign fault    = !is_aligned(addr_ext) || (idx >= IMEM_IDX_W'(DEPTH_WORDS));

   assign len_clamped = (load_len > CNT_W'(DEPTH_WORDS)) ? CNT_W'(DEPTH_WORDS) : load_len;

   assign load_ready = (state_q == ST_LOAD) && (len_q != '0);
   // A restart in the same cycle as a handshake discards that word
   assign accept     = load_ready && load_valid && !load_start;
   assign last_word  = accept && ((ptr_q + CNT_W'(1)) == len_q);
   assign fetch_go   = (state_q == ST_RUN) && fetch_req && !load_start;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (load_start) begin
               state_d = ST_LOAD;
            end else if (len_q == '0 || last_word) begin
               state_d = ST_RUN;
               done_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (load_start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         len_q         <= '0;
         ptr_q         <= '0;
         written_q     <= '0;
         load_done_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         addr_fault_q  <= 1'b0;
         resp_ram_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         load_done_q   <= done_d;
         instr_valid_q <= fetch_go;
         if (load_start) begin
            len_q     <= len_clamped;
            ptr_q     <= '0;
            written_q <= '0;
         end else if (accept) begin
            ptr_q                         <= ptr_q + CNT_W'(1);
            written_q[ptr_q[RAM_AW-1:0]]  <= 1'b1;
         end
         // Unwritten or faulted locations read as NOP instead of stale array data
         if (fetch_go) begin
            addr_fault_q <= fault;
            resp_ram_q   <= !fault && written_q[raddr];
         end
      end
   end

   imem_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (ptr_q[RAM_AW-1:0]),
      .wdata (load_data),
      .re    (fetch_go && !fault),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   assign load_done   = load_done_q;
   assign running     = (state_q == ST_RUN);
   assign instr_valid = instr_valid_q;
   assign addr_fault  = addr_fault_q;
   assign instruction = resp_ram_q ? ram_rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - randomized self-checking bench against an array-based reference model
module tb_instr_mem_loadable;

   localparam int DEPTH  = 20;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_n;
   logic              load_start;
   logic [CNT_W-1:0]  load_len;
   logic              load_valid;
   logic [31:0]       load_data;
   logic              load_ready;
   logic              load_done;
   logic              running;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic [31:0]       instruction;
   logic              instr_valid;
   logic              addr_fault;

   instr_mem_loadable #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (ADDR_W),
      .CNT_W       (CNT_W),
      .NOP_WORD    (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .load_len    (load_len),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .running     (running),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .addr_fault  (addr_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_mem [DEPTH];
   bit          model_wr  [DEPTH];
   bit          model_running;
   logic [31:0] last_instr;
   bit          last_fault;
   logic [31:0] words_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_wr[i] = 1'b0;
      model_running = 1'b0;
   endtask

   // gap_mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random
   task automatic do_load(input int len_in, input int gap_mode, input int abort_after, input bit with_fetch);
      int eff;
      int n;
      int cyc;
      bit v;
      logic [31:0] d;
      load_start = 1'b1;
      load_len   = CNT_W'(len_in);
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      fetch_req  = with_fetch;
      fetch_addr = '0;
      @(posedge clk); #1;
      load_start = 1'b0;
      load_valid = 1'b0;
      fetch_req  = 1'b0;
      if (with_fetch) begin
         check("start_beats_fetch_valid", {31'b0, instr_valid}, 32'd0);
         check("start_beats_fetch_hold", instruction, last_instr);
      end
      eff = (len_in > DEPTH) ? DEPTH : len_in;
      model_clear();
      n   = 0;
      cyc = 0;
      if (eff == 0) begin
         check("len0_ready", {31'b0, load_ready}, 32'd0);
         check("len0_done_early", {31'b0, load_done}, 32'd0);
         @(posedge clk); #1;
         check("len0_done", {31'b0, load_done}, 32'd1);
         check("len0_running", {31'b0, running}, 32'd1);
         model_running = 1'b1;
         @(posedge clk); #1;
         check("len0_done_once", {31'b0, load_done}, 32'd0);
         return;
      end
      while (n < eff) begin
         if (abort_after >= 0 && n == abort_after) return;
         check("load_ready", {31'b0, load_ready}, 32'd1);
         check("load_done_low", {31'b0, load_done}, 32'd0);
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = $urandom_range(0, 1) == 1;
         endcase
         d = (n < words_q.size()) ? words_q[n] : $urandom;
         load_valid = v;
         load_data  = d;
         @(posedge clk); #1;
         load_valid = 1'b0;
         cyc++;
         if (v) begin
            model_mem[n] = d;
            model_wr[n]  = 1'b1;
            n++;
         end
         if (cyc > 200) begin
            check("load_timeout", 32'd1, 32'd0);
            return;
         end
      end
      check("load_done_pulse", {31'b0, load_done}, 32'd1);
      check("load_ready_after", {31'b0, load_ready}, 32'd0);
      check("running_after_load", {31'b0, running}, 32'd1);
      model_running = 1'b1;
      load_valid = 1'b1;
      load_data  = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      load_valid = 1'b0;
      check("load_done_once", {31'b0, load_done}, 32'd0);
      check("no_extra_ready", {31'b0, load_ready}, 32'd0);
   endtask

   task automatic do_fetch(input logic [31:0] a);
      int unsigned idx;
      bit flt;
      bit exp_v;
      fetch_req  = 1'b1;
      fetch_addr = a;
      @(posedge clk); #1;
      fetch_req = 1'b0;
      exp_v = model_running;
      if (model_running) begin
         idx = a >> 2;
         flt = (a[1:0] != 2'b00) || (idx >= DEPTH);
         if (flt)                last_instr = 32'h0;
         else if (model_wr[idx]) last_instr = model_mem[idx];
         else                    last_instr = 32'h0;
         last_fault = flt;
      end
      check($sformatf("fetch_valid@%h", a), {31'b0, instr_valid}, {31'b0, exp_v});
      check($sformatf("fetch_instr@%h", a), instruction, last_instr);
      check($sformatf("fetch_fault@%h", a), {31'b0, addr_fault}, {31'b0, last_fault});
      @(posedge clk); #1;
      check("valid_one_cycle", {31'b0, instr_valid}, 32'd0);
      check("instr_held", instruction, last_instr);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      load_len   = '0;
      load_valid = 1'b0;
      load_data  = '0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      model_clear();
      last_instr = 32'h0;
      last_fault = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, load_ready}, 32'd0);
      check("rst_done", {31'b0, load_done}, 32'd0);
      check("rst_running", {31'b0, running}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_fault", {31'b0, addr_fault}, 32'd0);
      check("rst_instr", instruction, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_fetch(32'h0);

      words_q = '{32'h8E08_0000, 32'h8E09_0004, 32'h0128_4820};
      do_load(3, 1, -1, 1'b0);
      do_fetch(32'h0);
      do_fetch(32'h4);
      do_fetch(32'h8);
      do_fetch(32'h2);
      do_fetch(32'h50);
      do_fetch(32'hC);

      words_q = {};
      do_load(25, 2, -1, 1'b0);
      do_fetch(32'h4C);
      for (int i = 0; i < 30; i++) do_fetch($urandom_range(0, 32'h60));
      do_fetch(32'hFFFF_FFFC);

      do_load(5, 0, 2, 1'b0);
      do_fetch(32'h0);
      words_q = '{32'hAE09_0028};
      do_load(1, 0, -1, 1'b0);
      do_fetch(32'h0);
      do_fetch(32'h4);

      words_q = {};
      do_load(0, 0, -1, 1'b1);
      do_fetch(32'h0);

      do_load(4, 0, 2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", {31'b0, load_ready}, 32'd0);
      check("async_rst_running", {31'b0, running}, 32'd0);
      check("async_rst_instr", instruction, 32'h0);
      check("async_rst_fault", {31'b0, addr_fault}, 32'd0);
      #2;
      rst_n = 1'b1;
      model_clear();
      last_instr = 32'h0;
      last_fault = 1'b0;
      @(posedge clk); #1;
      check("post_rst_running", {31'b0, running}, 32'd0);
      do_fetch(32'h0);

      for (int r = 0; r < 4; r++) begin
         do_load($urandom_range(0, 25), 2, -1, $urandom_range(0, 1) == 1);
         for (int i = 0; i < 12; i++) do_fetch($urandom_range(0, 32'h58));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=%0d exp=%0d", n_checks, 0);
      $fatal(1);
   end

endmodule
